hls_deadlock_threshold_monitor: RTL and testbench
=================================================

# hls_deadlock_threshold_monitor

Parametrised per-process deadlock monitor for HLS dataflow regions in the network-stack IP cores. One instance attaches to each dataflow process. It watches that process's AXI-Stream blocking signals and its child-instance idle/block signals. A raw registered `block` flag is kept for compatibility. On top of that, the block adds:
- a persistence threshold,
- a sticky `deadlock` flag with a cause snapshot,
- a saturating stall counter,
- a software-style `clear`.

## Interface
Parameters:
- `N_AXIS`, 7: number of AXIS block inputs.
- `N_INST`, 9: number of child-instance idle inputs.
- `N_BLOCK`, 5: number of child-instance block inputs.
- `AXIS_MASK`, `7'b0000011`: AXIS inputs that count as blocking. Width is `N_AXIS`.
- `INST_MASK`, all zeros: instance block inputs that count as blocking. Width is `N_BLOCK`.
- `THRESH`, 16: consecutive qualified cycles needed to declare deadlock. Must satisfy 1 ≤ `THRESH` ≤ 2^`CNT_W`−1.
- `CNT_W`, 16: stall counter width.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `axis_block_sigs`, in, `N_AXIS`: per-channel stream-blocked flags.
- `inst_idle_sigs`, in, `N_INST`: per-child idle flags.
- `inst_block_sigs`, in, `N_BLOCK`: per-child blocked flags.
- `clear`, in, 1: synchronous clear of the sticky state.
- `block`, out, 1: registered raw qualified-block indication.
- `deadlock`, out, 1: sticky deadlock flag.
- `cause`, out, `N_BLOCK+N_AXIS`: snapshot `{inst_block_sigs&INST_MASK, axis_block_sigs&AXIS_MASK}` taken at deadlock entry.
- `stall_cycles`, out, `CNT_W`: consecutive qualified-cycle count, saturating.

## Operation
- `raw` is `|(axis_block_sigs&AXIS_MASK) | |(inst_block_sigs&INST_MASK)`.
- `qual` is `raw & ~(&inst_idle_sigs)`. When every child is idle, nothing counts as blocked.
- `block` is `qual` registered. It does not depend on the FSM state.
- FSM states are IDLE, SUSPECT and DEADLOCK. The counter is `stall_cycles`.
- IDLE:
  - `qual`=1: counter becomes 1. If `THRESH`=1, go to DEADLOCK, else go to SUSPECT.
  - `qual`=0: stay in IDLE, counter 0.
- SUSPECT:
  - `qual`=1: counter increments. When the new value equals `THRESH`, go to DEADLOCK.
  - `qual`=0: return to IDLE and counter becomes 0. A single gap restarts the count.
- DEADLOCK:
  - `deadlock`=1 and the state is held until `clear` or `reset`, even after `qual` falls.
  - The counter increments on each `qual`=1 cycle and holds on `qual`=0. It saturates at 2^`CNT_W`−1 and never wraps.
- `cause` is loaded with the masked vector on the same edge that enters DEADLOCK. It stays frozen until `clear` or `reset`, and is otherwise 0.
- `clear`=1: go to IDLE and set counter, `deadlock` and `cause` to 0.
  - `clear` beats any transition or increment on the same edge.
  - `clear` does not affect `block`.
  - `qual` in the `clear` cycle is discarded; counting restarts on the next edge.
- Priority order is `reset` > `clear` > FSM.
- Input X/Z handling is not required; inputs are registered HLS handshake signals.

## Timing
- Reset values: `block`=0, `deadlock`=0, `cause`=0, `stall_cycles`=0, state IDLE.
- Reset mid-count or in DEADLOCK behaves like power-on on the next edge.
- `block` latency is 1 cycle from `qual`.
- With `qual` high on consecutive edges e1..eK, `stall_cycles`=K after eK.
- `deadlock` rises on edge e`THRESH` and is visible in the following cycle. `cause` is valid in that same cycle.
- All outputs are registered. There is no combinational input→output path.

## Test plan
1. Reset behaviour: hold `reset`=1 for 3 cycles with all inputs random. All outputs must be 0 afterward.
2. Threshold exactly met: `THRESH`=16, `axis_block_sigs`=`7'b0000010` held 16 cycles, `inst_idle_sigs`=0.
   - `block`=1 from cycle 2.
   - `deadlock`=1 after edge 16.
   - `cause`=`12'h002`, `stall_cycles`=16.
3. Gap restarts count and masking applies:
   - `qual` for 15 cycles, 1 low cycle, then 15 more. `deadlock` stays 0, `stall_cycles` returns to 0 and then reaches 15.
   - `axis_block_sigs`=`7'b0000100` (masked out) gives `block`=0.
4. Idle gating: `axis_block_sigs`=`7'b0000001` with `inst_idle_sigs`=`9'h1FF` for 32 cycles. `block`=0, `deadlock`=0.
5. Sticky state, clear priority and saturation:
   - With `CNT_W`=4 and `THRESH`=3, hold `qual` for 20 cycles. Deadlock sets at edge 3 and `stall_cycles` saturates at 15.
   - Drop `qual`: `deadlock` stays 1.
   - Pulse `clear` in a cycle where `qual`=1: outputs become 0, except `block`=1.
6. Reset mid-DEADLOCK: assert `reset` for 1 cycle. All outputs become 0. Re-declaring deadlock then needs a fresh `THRESH` run.

Source files
------------

// File: rtl/hls_deadlock_threshold_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : hls_deadlock_threshold_monitor_if
// Purpose  : Bundles the blocking/idle observation inputs, the software clear
//            and the monitor status outputs of one dataflow-process monitor.
// Ports    : master - drives axis_block_sigs, inst_idle_sigs,
//                     inst_block_sigs and clear; reads the status outputs
//            slave  - the monitor side, the reverse of master
// Revision : 1.0 - initial release
// ============================================================================
interface hls_deadlock_threshold_monitor_if #(
  parameter int N_AXIS  = 7,
  parameter int N_INST  = 9,
  parameter int N_BLOCK = 5,
  parameter int CNT_W   = 16
);
  logic [N_AXIS-1:0]         axis_block_sigs;
  logic [N_INST-1:0]         inst_idle_sigs;
  logic [N_BLOCK-1:0]        inst_block_sigs;
  logic                      clear;
  logic                      block;
  logic                      deadlock;
  logic [N_BLOCK+N_AXIS-1:0] cause;
  logic [CNT_W-1:0]          stall_cycles;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    input  block, deadlock, cause, stall_cycles
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    output block, deadlock, cause, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/hls_deadlock_threshold_monitor.sv
`default_nettype none
// ============================================================================
// Module   : hls_deadlock_threshold_monitor
// Purpose  : Per-process deadlock monitor for an HLS dataflow region. Flags a
//            process as deadlocked once it has been blocked (and not fully
//            idle) for THRESH consecutive cycles, snapshots the blocking
//            cause, and counts stall cycles with saturation.
// Ports    : clock  - clock
//            reset  - synchronous, active-high reset
//            mon    - slave modport: blocking/idle inputs, clear, and the
//                     registered block/deadlock/cause/stall_cycles outputs
// Revision : 1.0 - initial release
// ============================================================================
module hls_deadlock_threshold_monitor #(
  parameter int                 N_AXIS    = 7,
  parameter int                 N_INST    = 9,
  parameter int                 N_BLOCK   = 5,
  parameter logic [N_AXIS-1:0]  AXIS_MASK = 7'b0000011,
  parameter logic [N_BLOCK-1:0] INST_MASK = '0,
  parameter int                 THRESH    = 16,
  parameter int                 CNT_W     = 16
) (
  input wire logic                       clock,
  input wire logic                       reset,
  hls_deadlock_threshold_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SUSPECT  = 2'd1,
    ST_DEADLOCK = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      block_q, block_d;
  logic                      deadlock_q, deadlock_d;
  logic [N_BLOCK+N_AXIS-1:0] cause_q, cause_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic [N_BLOCK+N_AXIS-1:0] masked;
  logic                      raw;
  logic                      qual;
  logic [CNT_W-1:0]          cnt_inc;

  assign masked  = {mon.inst_block_sigs & INST_MASK, mon.axis_block_sigs & AXIS_MASK};
  assign raw     = |masked;
  // A process whose children are all idle is finished, not stuck.
  assign qual    = raw & ~(&mon.inst_idle_sigs);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    deadlock_d = deadlock_q;
    cause_d    = cause_q;
    block_d    = qual;

    if (mon.clear) begin
      // Clear wins over any transition; qual this cycle is discarded.
      state_d    = ST_IDLE;
      cnt_d      = '0;
      deadlock_d = 1'b0;
      cause_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (qual) begin
            cnt_d = CNT_W'(1);
            if (THRESH == 1) begin
              state_d    = ST_DEADLOCK;
              deadlock_d = 1'b1;
              cause_d    = masked;
            end else begin
              state_d = ST_SUSPECT;
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_SUSPECT: begin
          if (qual) begin
            cnt_d = cnt_inc;
            if (cnt_inc == THRESH_C) begin
              state_d    = ST_DEADLOCK;
              deadlock_d = 1'b1;
              cause_d    = masked;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_DEADLOCK: begin
          // Sticky: only clear/reset leave this state.
          if (qual && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          deadlock_d = 1'b0;
          cause_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      deadlock_q <= 1'b0;
      cause_q    <= '0;
      block_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      deadlock_q <= deadlock_d;
      cause_q    <= cause_d;
      block_q    <= block_d;
    end
  end

  assign mon.block        = block_q;
  assign mon.deadlock     = deadlock_q;
  assign mon.cause        = cause_q;
  assign mon.stall_cycles = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hls_deadlock_threshold_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_hls_deadlock_threshold_monitor
// Purpose  : Directed self-checking bench. Instance A uses default
//            parameters (THRESH=16, CNT_W=16); instance B uses THRESH=3,
//            CNT_W=4 to reach saturation quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hls_deadlock_threshold_monitor;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   fails   = 0;

  always #5 clock = ~clock;

  hls_deadlock_threshold_monitor_if #(.N_AXIS(7), .N_INST(9), .N_BLOCK(5), .CNT_W(16)) if_a ();
  hls_deadlock_threshold_monitor_if #(.N_AXIS(7), .N_INST(9), .N_BLOCK(5), .CNT_W(4))  if_b ();

  hls_deadlock_threshold_monitor #(
    .N_AXIS(7), .N_INST(9), .N_BLOCK(5),
    .AXIS_MASK(7'b0000011), .INST_MASK(5'b00000),
    .THRESH(16), .CNT_W(16)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .mon   (if_a.slave)
  );

  hls_deadlock_threshold_monitor #(
    .N_AXIS(7), .N_INST(9), .N_BLOCK(5),
    .AXIS_MASK(7'b0000011), .INST_MASK(5'b00000),
    .THRESH(3), .CNT_W(4)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .mon   (if_b.slave)
  );

  // Advance one edge; outputs are observed 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_inputs();
    if_a.axis_block_sigs = '0; if_a.inst_idle_sigs = '0;
    if_a.inst_block_sigs = '0; if_a.clear = 1'b0;
    if_b.axis_block_sigs = '0; if_b.inst_idle_sigs = '0;
    if_b.inst_block_sigs = '0; if_b.clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_a.axis_block_sigs = 7'($urandom); if_a.inst_idle_sigs = 9'($urandom);
      if_a.inst_block_sigs = 5'($urandom); if_a.clear = 1'($urandom);
      if_b.axis_block_sigs = 7'($urandom); if_b.inst_idle_sigs = 9'($urandom);
      if_b.inst_block_sigs = 5'($urandom); if_b.clear = 1'($urandom);
      step();
    end
    vectors++; if (if_a.block !== 1'b0) begin fails++; $display("FAIL reset_a_block got=%b exp=0", if_a.block); end
    vectors++; if (if_a.deadlock !== 1'b0) begin fails++; $display("FAIL reset_a_deadlock got=%b exp=0", if_a.deadlock); end
    vectors++; if (if_a.cause !== 12'h000) begin fails++; $display("FAIL reset_a_cause got=%h exp=000", if_a.cause); end
    vectors++; if (if_a.stall_cycles !== 16'd0) begin fails++; $display("FAIL reset_a_stall got=%0d exp=0", if_a.stall_cycles); end
    vectors++; if (if_b.block !== 1'b0) begin fails++; $display("FAIL reset_b_block got=%b exp=0", if_b.block); end
    vectors++; if (if_b.deadlock !== 1'b0) begin fails++; $display("FAIL reset_b_deadlock got=%b exp=0", if_b.deadlock); end
    vectors++; if (if_b.cause !== 12'h000) begin fails++; $display("FAIL reset_b_cause got=%h exp=000", if_b.cause); end
    vectors++; if (if_b.stall_cycles !== 4'd0) begin fails++; $display("FAIL reset_b_stall got=%0d exp=0", if_b.stall_cycles); end
    zero_inputs();
    reset = 1'b0;
    step();
  endtask

  task automatic test_threshold();
    if_a.axis_block_sigs = 7'b0000010;
    for (int k = 1; k <= 16; k++) begin
      step();
      vectors++; if (if_a.block !== 1'b1) begin fails++; $display("FAIL thr_block k=%0d got=%b exp=1", k, if_a.block); end
      vectors++; if (if_a.stall_cycles !== 16'(k)) begin fails++; $display("FAIL thr_stall k=%0d got=%0d exp=%0d", k, if_a.stall_cycles, k); end
      vectors++; if (if_a.deadlock !== (k >= 16)) begin fails++; $display("FAIL thr_deadlock k=%0d got=%b exp=%b", k, if_a.deadlock, (k >= 16)); end
    end
    vectors++; if (if_a.cause !== 12'h002) begin fails++; $display("FAIL thr_cause got=%h exp=002", if_a.cause); end
    if_a.axis_block_sigs = '0;
    step();
    vectors++; if (if_a.deadlock !== 1'b1) begin fails++; $display("FAIL thr_sticky got=%b exp=1", if_a.deadlock); end
    vectors++; if (if_a.stall_cycles !== 16'd16) begin fails++; $display("FAIL thr_hold got=%0d exp=16", if_a.stall_cycles); end
    vectors++; if (if_a.cause !== 12'h002) begin fails++; $display("FAIL thr_cause_frozen got=%h exp=002", if_a.cause); end
    vectors++; if (if_a.block !== 1'b0) begin fails++; $display("FAIL thr_block_drop got=%b exp=0", if_a.block); end
    if_a.clear = 1'b1;
    step();
    if_a.clear = 1'b0;
    vectors++; if (if_a.deadlock !== 1'b0) begin fails++; $display("FAIL thr_clear_dl got=%b exp=0", if_a.deadlock); end
    vectors++; if (if_a.stall_cycles !== 16'd0) begin fails++; $display("FAIL thr_clear_stall got=%0d exp=0", if_a.stall_cycles); end
    vectors++; if (if_a.cause !== 12'h000) begin fails++; $display("FAIL thr_clear_cause got=%h exp=000", if_a.cause); end
  endtask

  task automatic test_gap_and_mask();
    if_a.axis_block_sigs = 7'b0000001;
    for (int k = 1; k <= 15; k++) begin
      step();
      vectors++; if (if_a.stall_cycles !== 16'(k)) begin fails++; $display("FAIL gap_first k=%0d got=%0d exp=%0d", k, if_a.stall_cycles, k); end
    end
    if_a.axis_block_sigs = '0;
    step();
    vectors++; if (if_a.stall_cycles !== 16'd0) begin fails++; $display("FAIL gap_reset got=%0d exp=0", if_a.stall_cycles); end
    if_a.axis_block_sigs = 7'b0000011;
    for (int k = 1; k <= 15; k++) begin
      step();
      vectors++; if (if_a.stall_cycles !== 16'(k)) begin fails++; $display("FAIL gap_second k=%0d got=%0d exp=%0d", k, if_a.stall_cycles, k); end
      vectors++; if (if_a.deadlock !== 1'b0) begin fails++; $display("FAIL gap_deadlock k=%0d got=%b exp=0", k, if_a.deadlock); end
    end
    if_a.axis_block_sigs = 7'b0000100;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++; if (if_a.block !== 1'b0) begin fails++; $display("FAIL mask_block got=%b exp=0", if_a.block); end
      vectors++; if (if_a.stall_cycles !== 16'd0) begin fails++; $display("FAIL mask_stall got=%0d exp=0", if_a.stall_cycles); end
    end
    if_a.axis_block_sigs = '0;
  endtask

  task automatic test_idle_gating();
    if_a.axis_block_sigs = 7'b0000001;
    if_a.inst_idle_sigs  = 9'h1FF;
    for (int k = 0; k < 32; k++) begin
      step();
      vectors++; if (if_a.block !== 1'b0) begin fails++; $display("FAIL idle_block k=%0d got=%b exp=0", k, if_a.block); end
      vectors++; if (if_a.deadlock !== 1'b0) begin fails++; $display("FAIL idle_deadlock k=%0d got=%b exp=0", k, if_a.deadlock); end
      vectors++; if (if_a.stall_cycles !== 16'd0) begin fails++; $display("FAIL idle_stall k=%0d got=%0d exp=0", k, if_a.stall_cycles); end
    end
    if_a.inst_idle_sigs = 9'h1FE;
    step();
    vectors++; if (if_a.block !== 1'b1) begin fails++; $display("FAIL idle_partial_block got=%b exp=1", if_a.block); end
    vectors++; if (if_a.stall_cycles !== 16'd1) begin fails++; $display("FAIL idle_partial_stall got=%0d exp=1", if_a.stall_cycles); end
    zero_inputs();
    step();
  endtask

  task automatic test_saturation_clear();
    if_b.axis_block_sigs = 7'b0000001;
    for (int k = 1; k <= 20; k++) begin
      step();
      vectors++; if (if_b.stall_cycles !== 4'((k > 15) ? 15 : k)) begin fails++; $display("FAIL sat_stall k=%0d got=%0d exp=%0d", k, if_b.stall_cycles, (k > 15) ? 15 : k); end
      vectors++; if (if_b.deadlock !== (k >= 3)) begin fails++; $display("FAIL sat_deadlock k=%0d got=%b exp=%b", k, if_b.deadlock, (k >= 3)); end
      if (k >= 3) begin
        vectors++; if (if_b.cause !== 12'h001) begin fails++; $display("FAIL sat_cause k=%0d got=%h exp=001", k, if_b.cause); end
      end
    end
    if_b.axis_block_sigs = '0;
    step();
    vectors++; if (if_b.deadlock !== 1'b1) begin fails++; $display("FAIL sat_sticky got=%b exp=1", if_b.deadlock); end
    vectors++; if (if_b.stall_cycles !== 4'd15) begin fails++; $display("FAIL sat_hold got=%0d exp=15", if_b.stall_cycles); end
    if_b.axis_block_sigs = 7'b0000010;
    if_b.clear = 1'b1;
    step();
    if_b.clear = 1'b0;
    vectors++; if (if_b.deadlock !== 1'b0) begin fails++; $display("FAIL clr_deadlock got=%b exp=0", if_b.deadlock); end
    vectors++; if (if_b.stall_cycles !== 4'd0) begin fails++; $display("FAIL clr_stall got=%0d exp=0", if_b.stall_cycles); end
    vectors++; if (if_b.cause !== 12'h000) begin fails++; $display("FAIL clr_cause got=%h exp=000", if_b.cause); end
    vectors++; if (if_b.block !== 1'b1) begin fails++; $display("FAIL clr_block got=%b exp=1", if_b.block); end
    step();
    vectors++; if (if_b.stall_cycles !== 4'd1) begin fails++; $display("FAIL clr_restart got=%0d exp=1", if_b.stall_cycles); end
    vectors++; if (if_b.deadlock !== 1'b0) begin fails++; $display("FAIL clr_restart_dl got=%b exp=0", if_b.deadlock); end
  endtask

  task automatic test_reset_mid_deadlock();
    step();
    step();
    vectors++; if (if_b.deadlock !== 1'b1) begin fails++; $display("FAIL mid_pre_dl got=%b exp=1", if_b.deadlock); end
    vectors++; if (if_b.cause !== 12'h002) begin fails++; $display("FAIL mid_pre_cause got=%h exp=002", if_b.cause); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++; if (if_b.deadlock !== 1'b0) begin fails++; $display("FAIL mid_rst_dl got=%b exp=0", if_b.deadlock); end
    vectors++; if (if_b.stall_cycles !== 4'd0) begin fails++; $display("FAIL mid_rst_stall got=%0d exp=0", if_b.stall_cycles); end
    vectors++; if (if_b.cause !== 12'h000) begin fails++; $display("FAIL mid_rst_cause got=%h exp=000", if_b.cause); end
    vectors++; if (if_b.block !== 1'b0) begin fails++; $display("FAIL mid_rst_block got=%b exp=0", if_b.block); end
    for (int k = 1; k <= 3; k++) begin
      step();
      vectors++; if (if_b.stall_cycles !== 4'(k)) begin fails++; $display("FAIL mid_rerun_stall k=%0d got=%0d exp=%0d", k, if_b.stall_cycles, k); end
      vectors++; if (if_b.deadlock !== (k == 3)) begin fails++; $display("FAIL mid_rerun_dl k=%0d got=%b exp=%b", k, if_b.deadlock, (k == 3)); end
    end
    zero_inputs();
  endtask

  initial begin
    zero_inputs();
    test_reset();
    test_threshold();
    test_gap_and_mask();
    test_idle_gating();
    test_saturation_clear();
    test_reset_mid_deadlock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
